// File: rtl/serial_mag_cmp_pkg.sv
// rtl/serial_mag_cmp_pkg.sv - shared state encoding and result helper for the bit-serial comparator
package serial_mag_cmp_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // Packs {gt, lt, eq}; an undecided comparison means every bit pair matched.
  function automatic logic [2:0] encode_result(input logic decided, input logic dec_gt);
    return {decided & dec_gt, decided & ~dec_gt, ~decided};
  endfunction

endpackage

// File: rtl/mag_cmp_1b.sv
// rtl/mag_cmp_1b.sv - 1-bit combinational magnitude comparator cell
module mag_cmp_1b (
  input  logic a,
  input  logic b,
  output logic gt,
  output logic lt,
  output logic eq
);

  assign gt = a & ~b;
  assign lt = ~a & b;
  assign eq = ~(a ^ b);

endmodule

// File: rtl/serial_mag_cmp.sv
// rtl/serial_mag_cmp.sv - bit-serial MSB-first magnitude comparator with held gt/lt/eq result
module serial_mag_cmp
  import serial_mag_cmp_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic bit_valid,
  input  logic a_bit,
  input  logic b_bit,
  output logic bit_ready,
  output logic busy,
  output logic done,
  output logic gt,
  output logic lt,
  output logic eq
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t        state;
  logic [CW-1:0] count;
  logic          decided;
  logic          dec_gt;

  logic cell_gt, cell_lt, cell_eq;
  logic beat, nxt_decided, nxt_dec_gt;

  mag_cmp_1b u_cell (
    .a  (a_bit),
    .b  (b_bit),
    .gt (cell_gt),
    .lt (cell_lt),
    .eq (cell_eq)
  );

  assign beat = bit_ready && bit_valid;

  // The first differing bit pair decides; later pairs cannot override it.
  assign nxt_decided = decided || !cell_eq;
  assign nxt_dec_gt  = decided ? dec_gt : (cell_gt && !cell_lt);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      count     <= '0;
      decided   <= 1'b0;
      dec_gt    <= 1'b0;
      bit_ready <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      gt        <= 1'b0;
      lt        <= 1'b0;
      eq        <= 1'b0;
    end else begin
      done <= 1'b0;
      // start wins in every state; a beat offered alongside it is dropped.
      if (start) begin
        state          <= S_SHIFT;
        count          <= '0;
        decided        <= 1'b0;
        dec_gt         <= 1'b0;
        bit_ready      <= 1'b1;
        busy           <= 1'b1;
        {gt, lt, eq}   <= 3'b000;
      end else begin
        case (state)
          S_IDLE: begin
          end
          S_SHIFT: begin
            if (beat) begin
              count   <= count + CW'(1);
              decided <= nxt_decided;
              dec_gt  <= nxt_dec_gt;
              if (count == LAST) begin
                state        <= S_DONE;
                bit_ready    <= 1'b0;
                done         <= 1'b1;
                {gt, lt, eq} <= encode_result(nxt_decided, nxt_dec_gt);
              end
            end
          end
          S_DONE: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state     <= S_IDLE;
            bit_ready <= 1'b0;
            busy      <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
